// File: rtl/fcs_rx.sv
// rtl/fcs_rx.sv - Ethernet receive FCS checker/stripper; optional frame counters under FCS_RX_STATS_EN

// One byte of reflected CRC-32 (poly 0xEDB88320), no final inversion
module fcs_crc32_byte (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Eight LSB-first shift/xor steps over the incoming byte
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ 32'hEDB88320) : (crc_out >> 1);
    end
  end

endmodule

module fcs_rx #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_W         = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_er,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             frame_done,
  output logic             frame_good,
  output logic             frame_bad,
  output logic [CNT_W-1:0] rx_len
`ifdef FCS_RX_STATS_EN
  ,
  output logic [31:0]      good_cnt,
  output logic [31:0]      bad_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK
  } state_t;

  localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;
  // Register value left after running the CRC over data plus a correct FCS
  localparam logic [31:0]      RESIDUE  = 32'hDEBB20E3;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_L    = CNT_W'(MIN_FRAME_LEN);
  localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_FRAME_LEN);
  localparam logic [CNT_W-1:0] FCS_LEN  = CNT_W'(4);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic [31:0]      crc;
  logic [31:0]      crc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       fill;
  logic             err;
  // sreg[0] is the newest byte, sreg[3] the oldest once four are held
  logic [7:0]       sreg [4];
  logic             good_w;
  logic [CNT_W-1:0] len_w;

  fcs_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (rx_data),
    .crc_out (crc_nxt)
  );

  assign good_w = (crc == RESIDUE) && (cnt >= MIN_L) && (cnt <= MAX_L) && !err;
  assign len_w  = (cnt >= FCS_LEN) ? (cnt - FCS_LEN) : '0;

  // Frame FSM: CRC accumulation, byte counting, 4-byte delay line and end-of-frame status
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= S_IDLE;
      crc        <= CRC_INIT;
      cnt        <= '0;
      fill       <= 3'd0;
      err        <= 1'b0;
      for (int i = 0; i < 4; i++) sreg[i] <= 8'h00;
      m_data     <= 8'h00;
      m_valid    <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      rx_len     <= '0;
    end else begin
      m_valid    <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            crc     <= crc_nxt;
            cnt     <= ONE;
            fill    <= 3'd1;
            err     <= rx_er;
            sreg[0] <= rx_data;
            state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (rx_valid) begin
            crc <= crc_nxt;
            if (cnt != CNT_MAX) cnt <= cnt + ONE;
            err     <= err | rx_er;
            sreg[0] <= rx_data;
            sreg[1] <= sreg[0];
            sreg[2] <= sreg[1];
            sreg[3] <= sreg[2];
            // Only bytes at least four behind the newest are payload; the rest may be FCS
            if (fill == 3'd4) begin
              m_data  <= sreg[3];
              m_valid <= 1'b1;
            end else begin
              fill <= fill + 3'd1;
            end
          end else begin
            frame_done <= 1'b1;
            frame_good <= good_w;
            frame_bad  <= !good_w;
            rx_len     <= len_w;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Bytes arriving here are dropped; the FCS left in sreg is discarded
          crc   <= CRC_INIT;
          cnt   <= '0;
          fill  <= 3'd0;
          err   <= 1'b0;
          for (int i = 0; i < 4; i++) sreg[i] <= 8'h00;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FCS_RX_STATS_EN
  // Saturating good/bad frame counters driven by the status pulses
  always_ff @(posedge aclk) begin
    if (areset) begin
      good_cnt <= 32'h0;
      bad_cnt  <= 32'h0;
    end else begin
      if (frame_good && (good_cnt != 32'hFFFFFFFF)) good_cnt <= good_cnt + 32'h1;
      if (frame_bad && (bad_cnt != 32'hFFFFFFFF))   bad_cnt  <= bad_cnt + 32'h1;
    end
  end
`endif

endmodule
